fetch_unit: RTL and testbench

Instruction fetch stage of the simplecpu core. Sits between the instruction memory (`instmem`, 1K x 16, synchronous read) and the execute unit. Generates the fetch PC, issues memory reads, and buffers returned instructions in a small queue. Presents them downstream over a valid/ready handshake and supports PC redirect for jumps and branches.

---
 rtl/fetch_unit.sv | 100 ++++++++++
 tb/tb_fetch_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: fetch PC generation, instmem read issue, QDEPTH-entry instruction queue, redirect.
// Define FETCH_HALT_EN to stop fetching after an opcode 4'hF instruction is queued.
module fetch_unit #(
  parameter int              PC_W     = 10,
  parameter int              INST_W   = 16,
  parameter int              QDEPTH   = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_ren,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [PC_W-1:0]   inst_pc,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              halted
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  logic [PC_W-1:0]   fetch_pc;
  logic [PC_W-1:0]   resp_pc;
  logic [INST_W-1:0] q_data [QDEPTH];
  logic [PC_W-1:0]   q_pc   [QDEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;
  logic              inflight, drop;
  logic              pop, push, room, halt_hit, halt_q;
  logic [CW:0]       occ, lim;

  assign inst_valid = (count != '0);
  assign inst_data  = inst_valid ? q_data[rd_ptr] : '0;
  assign inst_pc    = inst_valid ? q_pc[rd_ptr]   : '0;
  assign pop        = inst_valid && inst_ready;

  // Occupancy including the outstanding read must stay below QDEPTH after this cycle's pop.
  assign occ  = (CW+1)'(count) + (CW+1)'(inflight);
  assign lim  = (CW+1)'(QDEPTH) + (CW+1)'(pop);
  assign room = occ < lim;

  assign imem_ren  = !rst && (redirect_valid || (!halt_q && room));
  assign imem_addr = (!rst && redirect_valid) ? redirect_pc : fetch_pc;

  // A response landing in a redirect cycle is stale; the one after it belongs to the target.
  assign push = inflight && !drop && !redirect_valid;

`ifdef FETCH_HALT_EN
  assign halt_hit = push && (imem_rdata[15:12] == 4'hF);

  always_ff @(posedge clk) begin
    if (rst)                 halt_q <= 1'b0;
    else if (redirect_valid) halt_q <= 1'b0;
    else if (halt_hit)       halt_q <= 1'b1;
  end
`else
  assign halt_hit = 1'b0;
  assign halt_q   = 1'b0;
`endif

  assign halted = halt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= 1'b0;
      drop     <= 1'b0;
    end else begin
      inflight <= imem_ren;
      resp_pc  <= imem_addr;
      if (imem_ren) fetch_pc <= imem_addr + PC_W'(1);
      if (redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        drop   <= 1'b0;
      end else begin
        // The read issued alongside a halt push returns after fetch has stopped.
        drop <= halt_hit;
        if (push) begin
          q_data[wr_ptr] <= imem_rdata;
          q_pc[wr_ptr]   <= resp_pc;
          wr_ptr         <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && !pop && count == CW'(QDEPTH)));

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: instmem model, sequential-PC reference stream, directed and random phases.
module tb_fetch_unit;
  localparam int QD = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_ren;
  logic [9:0]  imem_addr;
  logic [15:0] imem_rdata = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [15:0] inst_data;
  logic [9:0]  inst_pc;
  logic        redirect_valid = 1'b0;
  logic [9:0]  redirect_pc = '0;
  logic        halted;

  fetch_unit #(.PC_W(10), .INST_W(16), .QDEPTH(QD), .RESET_PC(10'd0)) dut (
    .clk(clk), .rst(rst), .imem_ren(imem_ren), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halted(halted)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [1024];

  always @(posedge clk) if (imem_ren) imem_rdata <= mem[imem_addr];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: after reset or redirect, delivery is the strictly sequential PC stream
  // (mod 1024) starting at the restart address, each with the word stored there.
  typedef struct packed { logic [9:0] pc; logic [15:0] dat; } exp_t;
  exp_t       sb[$];
  logic [9:0] sb_next = '0;

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      sb_next = 10'd0;
    end else begin
      if (inst_valid) begin
        if (sb.size() == 0) check("sb_empty", 1, 0);
        else begin
          check("head_pc", inst_pc, sb[0].pc);
          check("head_data", inst_data, sb[0].dat);
          if (inst_ready) void'(sb.pop_front());
        end
      end else begin
        check("idle_data", inst_data, 0);
        check("idle_pc", inst_pc, 0);
      end
      if (redirect_valid) begin
        sb.delete();
        sb_next = redirect_pc;
      end
    end
    while (sb.size() < 8) begin
      sb.push_back({sb_next, mem[sb_next]});
      sb_next = sb_next + 10'd1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd_cnt, ren_cnt, p6, found;
    logic [9:0] wrap_pcs [4];
    wrap_pcs[0] = 10'd1022; wrap_pcs[1] = 10'd1023; wrap_pcs[2] = 10'd0; wrap_pcs[3] = 10'd1;

    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom) & 16'hEFFF;
    mem[0] = 16'h3102; mem[1] = 16'h3203; mem[2] = 16'h2312; mem[3] = 16'h3063;
    mem[5] = 16'hF000;

    // Reset values and first-fetch latency
    repeat (3) tick();
    @(negedge clk);
    check("rst_ren", imem_ren, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_valid", inst_valid, 0);
    check("rst_data", inst_data, 0);
    check("rst_pc", inst_pc, 0);
    check("rst_halted", halted, 0);
    tick();
    rst = 1'b0; inst_ready = 1'b1;
    @(negedge clk);
    check("pre_e0_ren", imem_ren, 1);
    check("pre_e0_addr", imem_addr, 0);
    tick();
    @(negedge clk);
    check("e0_valid", inst_valid, 0);
    tick();
    @(negedge clk);
    check("e1_valid", inst_valid, 1);
    check("e1_pc", inst_pc, 0);
    for (int i = 1; i < 4; i++) begin
      tick();
      @(negedge clk);
      check("stream_valid", inst_valid, 1);
      check("stream_pc", inst_pc, i);
    end

    // Backpressure from reset: only QDEPTH reads, head held
    tick();
    rst = 1'b1; inst_ready = 1'b0;
    tick();
    rst = 1'b0;
    rd_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (imem_ren) rd_cnt++;
      tick();
    end
    check("bp_reads", rd_cnt, QD);
    @(negedge clk);
    check("bp_head_pc", inst_pc, 0);
    check("bp_head_data", inst_data, 16'h3102);
    tick();
    inst_ready = 1'b1;
    repeat (10) tick();

    // Redirect to 12 while pc 3 is at the head
    rst = 1'b1;
    tick();
    rst = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (inst_valid && inst_pc == 10'd2) found = 1;
      tick();
    end
    check("find_pc2", found, 1);
    redirect_valid = 1'b1; redirect_pc = 10'd12;
    @(negedge clk);
    check("redir_head_pc3", inst_pc, 3);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("redir_gap_valid", inst_valid, 0);
    tick();
    @(negedge clk);
    check("redir_valid", inst_valid, 1);
    check("redir_pc", inst_pc, 12);
    check("redir_data", inst_data, mem[12]);

    // Redirect across the top of the address space
    tick();
    redirect_valid = 1'b1; redirect_pc = 10'd1022;
    tick();
    redirect_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("wrap_valid", inst_valid, 1);
      check("wrap_pc", inst_pc, wrap_pcs[i]);
      tick();
    end

    // Reset with a full queue
    inst_ready = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    check("full_valid", inst_valid, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", inst_valid, 0);
    check("mid_rst_ren", imem_ren, 1);
    check("mid_rst_addr", imem_addr, 0);
    tick();
    @(negedge clk);
    check("mid_rst_e0_valid", inst_valid, 0);
    tick();
    @(negedge clk);
    check("mid_rst_e1_valid", inst_valid, 1);
    check("mid_rst_e1_pc", inst_pc, 0);

    // Opcode F at pc 5
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; inst_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 30 && found == 0; i++) begin
      @(negedge clk);
      if (inst_valid && inst_pc == 10'd5) found = 1;
      else tick();
    end
    check("find_pc5", found, 1);
    check("pc5_data", inst_data, 16'hF000);
`ifdef FETCH_HALT_EN
    check("halt_set", halted, 1);
`else
    check("halt_tied", halted, 0);
`endif
    ren_cnt = 0; p6 = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      @(negedge clk);
      if (imem_ren) ren_cnt++;
      if (inst_valid && inst_pc == 10'd6) p6++;
    end
`ifdef FETCH_HALT_EN
    check("halt_no_ren", ren_cnt, 0);
    check("halt_no_pc6", p6, 0);
    check("halt_held", halted, 1);
`else
    check("plain_pc6_once", p6, 1);
`endif
    tick();
    redirect_valid = 1'b1; redirect_pc = 10'd0;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("halt_cleared", halted, 0);
    tick();
    @(negedge clk);
    check("resume_valid", inst_valid, 1);
    check("resume_pc", inst_pc, 0);

    // Random ready, redirects and resets; scoreboard checks every presented head
    for (int i = 0; i < 400; i++) begin
      tick();
      inst_ready     = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 99) < 4);
      redirect_pc    = 10'($urandom);
      rst            = ($urandom_range(0, 99) < 1);
    end
    tick();
    rst = 1'b0; redirect_valid = 1'b0;
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
